hidden_cpu_prog_fetch: RTL and testbench
========================================

Name: hidden_cpu_prog_fetch

Overview:
Instruction-supply stage that sits directly upstream of the hiddenCPU core. It holds a small program, loaded one beat at a time through a valid/ready port. In RUN it takes the PC the core drives on its output bus and returns the 6-bit instruction word {opcode[1:0], reg0Addr[1:0], reg1Addr[1:0]} that the core consumes on in[7:2]. It lets the core run a stored program instead of needing live pin stimulus.

Parameters:
DEPTH, 16, number of instruction slots (power of two, 2..256)
ADDR_W, 4, log2(DEPTH)
IW, 6, instruction width in bits: opcode[5:4], reg0Addr[3:2], reg1Addr[1:0]
NOP_INSTR, 6'b000000, word returned for out-of-range or not-running fetches

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
load_en  in  1  level; high requests load mode
load_valid  in  1  load beat valid
load_data  in  IW  instruction word being loaded
load_ready  out  1  slot available to accept a beat
pc_in  in  8  program counter from the core
pc_valid  in  1  fetch request for pc_in
instr_out  out  IW  fetched instruction
instr_valid  out  1  instr_out updated this cycle
prog_len  out  ADDR_W+1  number of loaded instructions, 0..DEPTH
running  out  1  high in RUN state
pc_oob  out  1  last fetch had pc_in >= prog_len
overflow  out  1  sticky; a beat was offered while memory was full

Behaviour:
- Reset, synchronous, dominates all inputs and is also taken mid-load or mid-run:
  - state=IDLE; prog_len=0; wr_ptr=0.
  - instr_out=NOP_INSTR; instr_valid=0; pc_oob=0; overflow=0; load_ready=0; running=0.
  - Memory array is not cleared. With prog_len=0 it is never read.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: load_en=1 goes to LOAD next cycle with wr_ptr=0, prog_len=0, overflow=0. Otherwise stay.
  - LOAD: load_ready = (wr_ptr < DEPTH), driven combinationally from state and wr_ptr.
    - When load_valid & load_ready: mem[wr_ptr]<=load_data; wr_ptr++; prog_len++.
    - When load_valid & !load_ready: beat dropped; overflow<=1.
    - load_en=0 with prog_len>0: go to RUN. load_en=0 with prog_len=0: go to IDLE.
    - A beat presented in the same cycle that load_en falls is still accepted if load_ready=1.
  - RUN: running=1; load_ready=0. load_en=1 goes back to LOAD, clearing wr_ptr, prog_len and overflow. A fetch in that same cycle is ignored.
- Fetch, RUN only:
  - Latency is one cycle. When pc_valid=1 at edge N, instr_out/instr_valid/pc_oob are valid after edge N.
  - pc_in < prog_len: instr_out=mem[pc_in[ADDR_W-1:0]], pc_oob=0.
  - pc_in >= prog_len, including pc_in >= DEPTH: instr_out=NOP_INSTR, pc_oob=1. There is no wrap-around; the core branch (pc+r3) may overshoot.
  - instr_valid=1 for exactly the cycle following each pc_valid. instr_out and pc_oob hold their last value otherwise.
  - pc_valid outside RUN: instr_valid stays 0 and instr_out is unchanged.
- Read-during-write cannot occur, because LOAD and RUN are exclusive.
- prog_len saturates at DEPTH. wr_ptr is ADDR_W+1 bits wide so "full" is unambiguous.

Test Plan:
- Reset mid-LOAD after 3 beats -> next cycle state=IDLE, prog_len=0, load_ready=0, instr_out=6'b000000, overflow=0.
- Load 4 words 0x05,0x1A,0x2F,0x30 then drop load_en -> running=1, prog_len=4. Fetch pc_in=0..3 -> instr_out 0x05,0x1A,0x2F,0x30 each one cycle after pc_valid, instr_valid pulses 1 cycle, pc_oob=0.
- After loading 4 words, fetch pc_in=4 and pc_in=200 -> instr_out=0x00, pc_oob=1, instr_valid=1.
- Stream 17 beats with DEPTH=16 -> load_ready falls after beat 16, prog_len=16, overflow=1. Fetch pc_in=15 returns beat 16's data.
- load_en pulse with no beats -> LOAD then IDLE, running=0. A pc_valid=1 then yields instr_valid=0.
- In RUN, assert load_en together with pc_valid -> no instr_valid, state=LOAD, prog_len=0. Reload 2 words, exit -> fetch pc_in=1 returns new word 2, pc_in=2 gives pc_oob=1.

Source files
------------

// File: rtl/hidden_cpu_prog_fetch.sv
// Instruction-supply stage for the hiddenCPU core: holds a small program loaded
// through a valid/ready port and returns instruction words for the core's PC.
module hidden_cpu_prog_fetch #(
    parameter int              DEPTH     = 16,
    parameter int              ADDR_W    = 4,
    parameter int              IW        = 6,
    parameter logic [IW-1:0]   NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [IW-1:0]     load_data,
    output logic              load_ready,
    input  logic [7:0]        pc_in,
    input  logic              pc_valid,
    output logic [IW-1:0]     instr_out,
    output logic              instr_valid,
    output logic [ADDR_W:0]   prog_len,
    output logic              running,
    output logic              pc_oob,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t          state, state_nxt;
    logic [ADDR_W:0] wr_ptr;
    logic [IW-1:0]   mem [DEPTH];
    logic            beat_acc, beat_drop, fetch_go, restart;
    logic [8:0]      pc_ext, len_ext;
    logic [IW-1:0]   instr_p1;
    logic            oob_p1, vld_p1, ovf_r;

    always_comb begin
        load_ready = (state == S_LOAD) && (wr_ptr < FULL);
        beat_acc   = load_valid && load_ready;
        beat_drop  = (state == S_LOAD) && load_valid && !load_ready;
        fetch_go   = (state == S_RUN) && !load_en && pc_valid;
        restart    = (state != S_LOAD) && load_en;
        pc_ext     = {1'b0, pc_in};
        len_ext    = 9'(wr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // A beat accepted in the same cycle load_en falls still counts as a program.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (load_en) state_nxt = S_LOAD;
            S_LOAD: if (!load_en) state_nxt = ((wr_ptr != '0) || beat_acc) ? S_RUN : S_IDLE;
            S_RUN:  if (load_en) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // wr_ptr doubles as prog_len; it stops at DEPTH because load_ready gates it.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            wr_ptr <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (beat_acc)  wr_ptr <= wr_ptr + 1'b1;
            if (beat_drop) ovf_r  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_acc) mem[wr_ptr[ADDR_W-1:0]] <= load_data;
    end

    // Fetch stage boundary: one-cycle read, out-of-range PCs return NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= NOP_INSTR;
            oob_p1   <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= fetch_go;
            if (fetch_go) begin
                if (pc_ext < len_ext) begin
                    instr_p1 <= mem[pc_in[ADDR_W-1:0]];
                    oob_p1   <= 1'b0;
                end else begin
                    instr_p1 <= NOP_INSTR;
                    oob_p1   <= 1'b1;
                end
            end
        end
    end

    assign instr_out   = instr_p1;
    assign instr_valid = vld_p1;
    assign pc_oob      = oob_p1;
    assign overflow    = ovf_r;
    assign prog_len    = wr_ptr;
    assign running     = (state == S_RUN);

endmodule

// File: tb/tb_hidden_cpu_prog_fetch.sv
// Randomized self-checking bench for hidden_cpu_prog_fetch against a program-list model.
module tb_hidden_cpu_prog_fetch;

    localparam int DEPTH = 16;
    localparam int ADDR_W = 4;
    localparam int IW = 6;

    logic              clk = 1'b0;
    logic              rst, load_en, load_valid, pc_valid;
    logic [IW-1:0]     load_data;
    logic [7:0]        pc_in;
    logic              load_ready, instr_valid, running, pc_oob, overflow;
    logic [IW-1:0]     instr_out;
    logic [ADDR_W:0]   prog_len;

    int total = 0;
    int bad = 0;

    // Model: the program is simply the first DEPTH words offered in a load session.
    logic [IW-1:0] prog_q[$];
    int            m_len;
    logic          m_ovf;
    logic [IW-1:0] m_instr;
    logic          m_oob;

    hidden_cpu_prog_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IW(IW), .NOP_INSTR(6'b000000)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .pc_in(pc_in),
        .pc_valid(pc_valid), .instr_out(instr_out), .instr_valid(instr_valid),
        .prog_len(prog_len), .running(running), .pc_oob(pc_oob), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer every word of words[] in one session, then drop load_en to run.
    task automatic load_prog(input logic [IW-1:0] words[$]);
        load_en = 1'b1;
        step();
        prog_q = {};
        m_ovf = 1'b0;
        foreach (words[i]) begin
            total++;
            if (load_ready !== (i < DEPTH)) begin
                bad++;
                $display("FAIL load_ready beat%0d: got %b want %b", i, load_ready, i < DEPTH);
            end
            load_valid = 1'b1;
            load_data  = words[i];
            if (i < DEPTH) prog_q.push_back(words[i]);
            else           m_ovf = 1'b1;
            step();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        step();
        m_len = prog_q.size();
        total++;
        if (running !== 1'b1 || prog_len !== (ADDR_W+1)'(m_len) || overflow !== m_ovf) begin
            bad++;
            $display("FAIL load_done: running=%b prog_len=%0d ovf=%b want 1 %0d %b",
                     running, prog_len, overflow, m_len, m_ovf);
        end
    endtask

    task automatic fetch_check(input int pc);
        if (pc < m_len) begin m_instr = prog_q[pc]; m_oob = 1'b0; end
        else            begin m_instr = 6'b000000;  m_oob = 1'b1; end
        pc_in = 8'(pc);
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        pc_in = 8'($urandom_range(0, 255));
        total++;
        if (instr_valid !== 1'b1 || instr_out !== m_instr || pc_oob !== m_oob) begin
            bad++;
            $display("FAIL fetch pc=%0d: vld=%b instr=%h oob=%b want 1 %h %b",
                     pc, instr_valid, instr_out, pc_oob, m_instr, m_oob);
        end
        step();
        total++;
        if (instr_valid !== 1'b0 || instr_out !== m_instr || pc_oob !== m_oob) begin
            bad++;
            $display("FAIL fetch_hold pc=%0d: vld=%b instr=%h oob=%b want 0 %h %b",
                     pc, instr_valid, instr_out, pc_oob, m_instr, m_oob);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++;
        if (prog_len !== '0 || running !== 0 || load_ready !== 0 || instr_out !== 6'h00 ||
            instr_valid !== 0 || overflow !== 0 || pc_oob !== 0) begin
            bad++;
            $display("FAIL reset: len=%0d run=%b rdy=%b instr=%h vld=%b ovf=%b oob=%b",
                     prog_len, running, load_ready, instr_out, instr_valid, overflow, pc_oob);
        end
        load_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 6'($urandom);
            step();
        end
        total++;
        if (prog_len !== 5'd3) begin
            bad++;
            $display("FAIL preload_len: got %0d want 3", prog_len);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; load_valid = 1'b0; load_en = 1'b0;
        total++;
        if (prog_len !== '0 || load_ready !== 0 || running !== 0 || instr_out !== 6'h00 || overflow !== 0) begin
            bad++;
            $display("FAIL reset_midload: len=%0d rdy=%b run=%b instr=%h ovf=%b want 0 0 0 00 0",
                     prog_len, load_ready, running, instr_out, overflow);
        end
        m_len = 0;
        m_instr = 6'h00;
        step();
    endtask

    task automatic test_load_fetch();
        logic [IW-1:0] w[$];
        w = {6'h05, 6'h1A, 6'h2F, 6'h30};
        load_prog(w);
        for (int p = 0; p < 4; p++) fetch_check(p);
    endtask

    task automatic test_oob();
        fetch_check(4);
        fetch_check(200);
        fetch_check(2);
    endtask

    task automatic test_overflow();
        logic [IW-1:0] w[$];
        for (int i = 0; i < DEPTH + 1; i++) w.push_back(6'($urandom));
        load_prog(w);
        fetch_check(15);
        fetch_check(16);
        for (int i = 0; i < 6; i++) fetch_check($urandom_range(0, 17));
    endtask

    task automatic test_empty_load();
        logic [IW-1:0] held;
        held = instr_out;
        load_en = 1'b1;
        step();
        load_en = 1'b0;
        step();
        m_len = 0;
        total++;
        if (running !== 1'b0 || load_ready !== 1'b0 || prog_len !== '0) begin
            bad++;
            $display("FAIL empty_load: run=%b rdy=%b len=%0d want 0 0 0", running, load_ready, prog_len);
        end
        pc_in = 8'd0; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instr_out !== held) begin
            bad++;
            $display("FAIL idle_fetch: vld=%b instr=%h want 0 %h", instr_valid, instr_out, held);
        end
    endtask

    task automatic test_reload();
        logic [IW-1:0] w[$];
        logic [IW-1:0] held;
        w = {6'h11, 6'h22, 6'h33, 6'h3C};
        load_prog(w);
        fetch_check(3);
        held = instr_out;
        load_en = 1'b1; pc_valid = 1'b1; pc_in = 8'd1;
        step();
        pc_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instr_out !== held || prog_len !== '0 ||
            running !== 1'b0 || load_ready !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reload_entry: vld=%b instr=%h len=%0d run=%b rdy=%b ovf=%b",
                     instr_valid, instr_out, prog_len, running, load_ready, overflow);
        end
        w = {6'h2A, 6'h15};
        load_prog(w);
        fetch_check(1);
        fetch_check(2);
        fetch_check(0);
    endtask

    task automatic test_random();
        logic [IW-1:0] w[$];
        int n;
        for (int r = 0; r < 4; r++) begin
            w = {};
            n = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < n; i++) w.push_back(6'($urandom));
            load_prog(w);
            for (int k = 0; k < 8; k++)
                fetch_check(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, m_len));
        end
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
        pc_in = '0; pc_valid = 1'b0;
        m_len = 0; m_ovf = 1'b0; m_instr = '0; m_oob = 1'b0;
        test_reset();
        test_load_fetch();
        test_oob();
        test_overflow();
        test_empty_load();
        test_reload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
